hilo_ctrl: RTL and testbench
============================

# hilo_ctrl

Sequencer and owner of the HI/LO register pair for the MIPS32 core's Execute stage. Accepts HILO-class operations from the pipeline and launches them on a shared external iterative divider and a fixed-latency pipelined multiplier. Tracks the one in-flight long operation, performs accumulate (MADD/MSUB) commits, and raises a stall whenever a later HILO access would hit an operation that has not finished. The rest of the ALU sees only `hi`, `lo`, and `hilo_stall`.

## Interface
- `MUL_LAT`, default 2: multiplier latency in cycles from `mul_start` to a valid `mul_product`. Legal range 1..7.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `op_valid` in 1: a HILO-class operation is present in EX this cycle.
- `op_code` in 4: 0 DIV, 1 DIVU, 2 MULT, 3 MULTU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO, 10 MFHI, 11 MFLO; 12..15 illegal.
- `op_a`, `op_b` in 32 each: source operands (rs, rt).
- `ex_stall`, `ex_flush` in 1 each: an EX-stage stall or flush.
- `div_start` out 1: one-cycle launch pulse to the divider. `div_signed` out 1 qualifies it.
- `div_done` in 1: divider result valid, one-cycle pulse.
- `div_quotient`, `div_remainder` in 32 each: divider results.
- `mul_start` out 1: one-cycle launch pulse to the multiplier. `mul_signed` out 1 qualifies it.
- `mul_product` in 64: multiplier result, valid `MUL_LAT` cycles after `mul_start`.
- `hi`, `lo` out 32 each: current HI/LO contents, registered.
- `hilo_stall` out 1: the pipeline must hold EX.
- `busy` out 1: a long operation is in flight.
- `op_illegal` out 1: one-cycle pulse when an operation is rejected.

## Operation
- States: IDLE, MUL, DIV. Reset enters IDLE.
- An operation is accepted when all of these hold: `op_valid`, `~ex_stall`, `~ex_flush`, state IDLE, `op_code` legal.
- Accepted MTHI: `hi <= op_a` at the next edge. Accepted MTLO: `lo <= op_b` at the next edge.
- MFHI/MFLO change no state. Their data is already on `hi`/`lo`.
- Accepted MULT family:
  - `mul_start` pulses combinationally in the accept cycle. `mul_signed` is 1 for MULT, MADD, MSUB.
  - The accumulate kind is latched, and a counter loads `MUL_LAT-1`. State goes to MUL.
  - In MUL the counter decrements. When it reaches 0, the commit edge writes `{hi,lo}` as follows:
    - MULT/MULTU: `mul_product`.
    - MADD/MADDU: `{hi,lo} + mul_product`.
    - MSUB/MSUBU: `{hi,lo} - mul_product`.
  - The commit uses 64-bit modular arithmetic with no overflow flag. State then returns to IDLE.
- Accepted DIV/DIVU:
  - `div_start` pulses combinationally in the accept cycle, with `div_signed` = (op==DIV). State goes to DIV.
  - On `div_done`: `hi <= div_remainder`, `lo <= div_quotient`, state returns to IDLE.
  - Divide-by-zero is not checked; the divider's output is committed unchanged.
- `div_done` while not in DIV is ignored.
- `busy` = state != IDLE.
- `hilo_stall` = `op_valid & busy`. Every HILO access stalls while busy, which covers RAW/WAW on HI/LO.
- Flush does not abort an in-flight MUL/DIV. The launch was architecturally committed, so the result still commits.
- `ex_stall` or `ex_flush` in IDLE: the operation is not accepted, no start pulse is issued, and `op_illegal` stays low.
- `op_illegal` pulses in the cycle an otherwise-acceptable operation has an illegal `op_code`. HILO is unchanged.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `hilo_stall`=0, `div_start`=0, `mul_start`=0, `op_illegal`=0.
- `div_signed` and `mul_signed` are 0 whenever their start pulse is low.
- MTHI/MTLO: accepted in cycle t; new value visible in t+1.
- MULT family: accepted in t; `busy` is high in t+1..t+`MUL_LAT`; new HILO visible in t+`MUL_LAT`+1. The next HILO operation can be accepted in t+`MUL_LAT`+1.
- DIV: `div_done` in cycle d; HILO updated and `busy` low in d+1. An operation waiting in cycle d is still stalled and is accepted in d+1.
- Reset asserted mid-operation: immediately IDLE, HILO cleared, no commit. A later `div_done` is ignored.
- Back-to-back MADD: the second is accepted on the commit-following cycle and accumulates onto the committed value.

## Configuration
- `HILO_CTRL_ACC_EN` defined: MADD, MADDU, MSUB, MSUBU are legal and accumulate as above.
- Not defined: op_codes 4..7 are treated as illegal (`op_illegal` pulse, no start pulse, HILO unchanged), and the accumulate adder/subtractor is not synthesized.

## Test plan
- Reset, then MTHI `op_a`=0x12345678 and MTLO `op_b`=0x9ABCDEF0 -> `hi`=0x12345678 and `lo`=0x9ABCDEF0 one cycle after each.
- MULT with 0xFFFFFFFF × 2, `MUL_LAT`=2 -> `mul_start`/`mul_signed`=1; `{hi,lo}`=0xFFFFFFFF_FFFFFFFE visible 3 cycles after accept.
- DIVU 100/7, `div_done` 32 cycles later with q=14, r=2; MFLO presented during busy -> `hilo_stall` high until the cycle after `div_done`; then `lo`=14, `hi`=2.
- With `HILO_CTRL_ACC_EN`: HILO=0x0_00000005, MSUBU 3×2 -> HILO=0xFFFFFFFF_FFFFFFFF. Without the macro, the same op -> `op_illegal` pulse and HILO stays 5.
- DIV launched, then `ex_flush` for 3 cycles, then `div_done` -> HILO still commits; an MTHI with `ex_flush` in IDLE -> no change.
- Assert `reset` two cycles after a DIV launch -> `busy`=0 and HILO=0 immediately; a stray `div_done` afterwards leaves HILO at 0.

Source files
------------

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register owner and HILO-operation sequencer for the EX stage.
// Launches divides on a shared external iterative divider and multiplies on an
// external fixed-latency multiplier. It commits their results into HI/LO and
// stalls later HILO accesses while the single long operation is in flight.
// Optional feature macro: HILO_CTRL_ACC_EN enables MADD/MADDU/MSUB/MSUBU
// accumulation. Without it, op_codes 4..7 are rejected as illegal.
module hilo_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        ex_stall,
  input  logic        ex_flush,
  output logic        div_start,
  output logic        div_signed,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic        mul_start,
  output logic        mul_signed,
  input  logic [63:0] mul_product,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        hilo_stall,
  output logic        busy,
  output logic        op_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [3:0] OP_DIV   = 4'd0;
  localparam logic [3:0] OP_DIVU  = 4'd1;
  localparam logic [3:0] OP_MULT  = 4'd2;
  localparam logic [3:0] OP_MULTU = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;
  localparam logic [3:0] OP_MFHI  = 4'd10;
  localparam logic [3:0] OP_MFLO  = 4'd11;

  // The counter is preloaded so that it reaches zero in the cycle where the
  // multiplier product becomes valid.
  localparam logic [2:0] CNT_INIT = 3'(MUL_LAT - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic        op_legal;
  logic        can_issue;
  logic        accept;
  logic        is_mul;
  logic        is_div;
  logic [63:0] mul_result;

`ifdef HILO_CTRL_ACC_EN
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;
  acc_t acc;
`endif

  // Decode which op_codes this build supports.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    op_legal = 1'b0;
    case (op_code)
      OP_DIV, OP_DIVU, OP_MULT, OP_MULTU,
      OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: op_legal = 1'b1;
`ifdef HILO_CTRL_ACC_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  // Accept / reject decision and the combinational launch pulses.
  assign can_issue  = op_valid & ~ex_stall & ~ex_flush & (state == S_IDLE);
  assign accept     = can_issue & op_legal;
  assign op_illegal = can_issue & ~op_legal;
  assign is_mul     = accept & (op_code inside {[OP_MULT:OP_MSUBU]});
  assign is_div     = accept & (op_code inside {OP_DIV, OP_DIVU});

  // Even op_codes within the DIV and MULT families are the signed variants.
  assign mul_start  = is_mul;
  assign mul_signed = is_mul & ~op_code[0];
  assign div_start  = is_div;
  assign div_signed = is_div & ~op_code[0];

  assign busy       = (state != S_IDLE);
  assign hilo_stall = op_valid & busy;

  // Value written into {hi,lo} on the multiply commit edge (64-bit modular).
  always_comb begin
    mul_result = mul_product;
`ifdef HILO_CTRL_ACC_EN
    case (acc)
      ACC_ADD: mul_result = {hi, lo} + mul_product;
      ACC_SUB: mul_result = {hi, lo} - mul_product;
      default: mul_result = mul_product;
    endcase
`endif
  end

  // Sequencer FSM and HI/LO register file.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
`ifdef HILO_CTRL_ACC_EN
      acc   <= ACC_NONE;
`endif
    end else begin
      // NOTE: all state updates use non-blocking assignments, so every
      // right-hand side sees the values from before this edge.
      case (state)
        S_IDLE: begin
          if (is_mul) begin
            state <= S_MUL;
            cnt   <= CNT_INIT;
`ifdef HILO_CTRL_ACC_EN
            acc   <= op_code[2] ? (op_code[1] ? ACC_SUB : ACC_ADD) : ACC_NONE;
`endif
          end else if (is_div) begin
            state <= S_DIV;
          end else if (accept) begin
            if (op_code == OP_MTHI) hi <= op_a;
            if (op_code == OP_MTLO) lo <= op_b;
          end
        end
        S_MUL: begin
          if (cnt == 3'd0) begin
            {hi, lo} <= mul_result;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_DIV: begin
          // A flush does not abort the divide: the launch already committed.
          if (div_done) begin
            hi    <= div_remainder;
            lo    <= div_quotient;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl (MUL_LAT = 2). Expected HI/LO values are
// pushed to a scoreboard queue when the stimulus is driven. They are popped
// and compared when the DUT should show them. The multiplier is modelled
// in the bench.
module tb_hilo_ctrl;

  localparam int MUL_LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        ex_stall, ex_flush;
  logic        div_start, div_signed, div_done;
  logic [31:0] div_quotient, div_remainder;
  logic        mul_start, mul_signed;
  logic [63:0] mul_product;
  logic [31:0] hi, lo;
  logic        hilo_stall, busy, op_illegal;

  hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .div_start(div_start), .div_signed(div_signed), .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .mul_start(mul_start), .mul_signed(mul_signed), .mul_product(mul_product),
    .hi(hi), .lo(lo), .hilo_stall(hilo_stall), .busy(busy),
    .op_illegal(op_illegal)
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  logic [63:0] m_hilo;
  logic [63:0] mpipe[MUL_LAT];

  localparam logic [63:0] JUNK64 = 64'hDEAD_BEEF_0BAD_F00D;

  // Called at a negedge: sample the launch, advance one clock, shift the
  // multiplier model pipeline.
  task automatic step();
    logic        launch;
    logic [63:0] p;
    launch = mul_start;
    p = {{32{mul_signed & op_a[31]}}, op_a} * {{32{mul_signed & op_b[31]}}, op_b};
    @(posedge clock);
    #1;
    for (int i = MUL_LAT - 1; i > 0; i--) mpipe[i] = mpipe[i-1];
    mpipe[0]    = launch ? p : JUNK64;
    mul_product = mpipe[MUL_LAT-1];
  endtask

  task automatic idle();
    op_valid = 1'b0; op_code = 4'd0; op_a = 32'd0; op_b = 32'd0;
    ex_stall = 1'b0; ex_flush = 1'b0; div_done = 1'b0;
    div_quotient = 32'hDEAD_0001; div_remainder = 32'hDEAD_0002;
  endtask

  task automatic drive(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
  endtask

  task automatic load_hilo(input logic [31:0] h, input logic [31:0] l);
    drive(4'd8, h, 32'd0); @(negedge clock); step();
    drive(4'd9, 32'd0, l); @(negedge clock); step();
    idle();
    m_hilo = {h, l};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    @(negedge clock);
    n_vec++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    n_vec++; if ({busy, hilo_stall, div_start, mul_start, op_illegal} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got=%b exp=00000", {busy, hilo_stall, div_start, mul_start, op_illegal}); end
    step();
    reset = 1'b0;
    m_hilo = 64'd0;
    // A stray div_done in IDLE must be ignored.
    div_done = 1'b1; div_quotient = 32'h77; div_remainder = 32'h77;
    exp_q.push_back(m_hilo);
    @(negedge clock); step(); idle();
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({hi, lo} !== exp_v) begin n_err++; $display("FAIL stray_done got=%h exp=%h", {hi, lo}, exp_v); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stray_done_busy got=%b exp=0", busy); end
    step();
  endtask

  task automatic test_mthi_mtlo();
    drive(4'd8, 32'h1234_5678, 32'hFFFF_FFFF);
    m_hilo = {32'h1234_5678, m_hilo[31:0]};
    exp_q.push_back(m_hilo);
    @(negedge clock); step(); idle();
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({hi, lo} !== exp_v) begin n_err++; $display("FAIL mthi got=%h exp=%h", {hi, lo}, exp_v); end
    step();
    drive(4'd9, 32'hFFFF_FFFF, 32'h9ABC_DEF0);
    m_hilo = {m_hilo[63:32], 32'h9ABC_DEF0};
    exp_q.push_back(m_hilo);
    @(negedge clock); step(); idle();
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({hi, lo} !== exp_v) begin n_err++; $display("FAIL mtlo got=%h exp=%h", {hi, lo}, exp_v); end
    step();
  endtask

  task automatic test_mult();
    drive(4'd2, 32'hFFFF_FFFF, 32'd2);
    @(negedge clock);
    n_vec++; if ({mul_start, mul_signed, div_start} !== 3'b110) begin
      n_err++; $display("FAIL mult_launch got=%b exp=110", {mul_start, mul_signed, div_start}); end
    m_hilo = 64'hFFFF_FFFF_FFFF_FFFE;
    exp_q.push_back(m_hilo);
    step(); idle();
    for (int k = 1; k <= MUL_LAT; k++) begin
      @(negedge clock);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mult_busy cyc=%0d got=%b exp=1", k, busy); end
      step();
    end
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({hi, lo} !== exp_v) begin n_err++; $display("FAIL mult_hilo got=%h exp=%h", {hi, lo}, exp_v); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mult_done_busy got=%b exp=0", busy); end
    step();
  endtask

  task automatic test_div();
    drive(4'd1, 32'd100, 32'd7);
    @(negedge clock);
    n_vec++; if ({div_start, div_signed, mul_start} !== 3'b100) begin
      n_err++; $display("FAIL divu_launch got=%b exp=100", {div_start, div_signed, mul_start}); end
    step(); idle();
    drive(4'd11, 32'd0, 32'd0);
    for (int k = 1; k < 32; k++) begin
      @(negedge clock);
      n_vec++; if ({hilo_stall, div_start} !== 2'b10) begin
        n_err++; $display("FAIL divu_stall cyc=%0d got=%b exp=10", k, {hilo_stall, div_start}); end
      step();
    end
    div_done = 1'b1; div_quotient = 32'd14; div_remainder = 32'd2;
    m_hilo = {32'd2, 32'd14};
    exp_q.push_back(m_hilo);
    @(negedge clock);
    n_vec++; if (hilo_stall !== 1'b1) begin n_err++; $display("FAIL divu_done_stall got=%b exp=1", hilo_stall); end
    step();
    div_done = 1'b0; div_quotient = 32'hDEAD_0001; div_remainder = 32'hDEAD_0002;
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({hi, lo} !== exp_v) begin n_err++; $display("FAIL divu_hilo got=%h exp=%h", {hi, lo}, exp_v); end
    n_vec++; if ({busy, hilo_stall} !== 2'b00) begin
      n_err++; $display("FAIL divu_release got=%b exp=00", {busy, hilo_stall}); end
    step(); idle();
  endtask

  task automatic test_accumulate();
    load_hilo(32'd0, 32'd5);
    drive(4'd7, 32'd3, 32'd2);
    @(negedge clock);
`ifdef HILO_CTRL_ACC_EN
    n_vec++; if ({mul_start, mul_signed, op_illegal} !== 3'b100) begin
      n_err++; $display("FAIL msubu_launch got=%b exp=100", {mul_start, mul_signed, op_illegal}); end
    m_hilo = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_q.push_back(m_hilo);
    step(); idle();
    for (int k = 1; k <= MUL_LAT; k++) begin @(negedge clock); step(); end
`else
    n_vec++; if ({mul_start, div_start, op_illegal} !== 3'b001) begin
      n_err++; $display("FAIL msubu_reject got=%b exp=001", {mul_start, div_start, op_illegal}); end
    exp_q.push_back(m_hilo);
    step(); idle();
`endif
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({hi, lo} !== exp_v) begin n_err++; $display("FAIL msubu_hilo got=%h exp=%h", {hi, lo}, exp_v); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL msubu_busy got=%b exp=0", busy); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  code;
    logic [63:0] first;
`ifdef HILO_CTRL_ACC_EN
    code  = 4'd5;
    first = m_hilo + 64'd12;
`else
    code  = 4'd3;
    first = 64'd12;
`endif
    drive(code, 32'd3, 32'd4);
    exp_q.push_back(first);
    @(negedge clock);
    n_vec++; if (mul_start !== 1'b1) begin n_err++; $display("FAIL b2b_first_start got=%b exp=1", mul_start); end
    step();
    drive(code, 32'd5, 32'd6);
    for (int k = 1; k <= MUL_LAT; k++) begin
      @(negedge clock);
      n_vec++; if ({hilo_stall, mul_start} !== 2'b10) begin
        n_err++; $display("FAIL b2b_stall cyc=%0d got=%b exp=10", k, {hilo_stall, mul_start}); end
      step();
    end
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({hi, lo} !== exp_v) begin n_err++; $display("FAIL b2b_first got=%h exp=%h", {hi, lo}, exp_v); end
    n_vec++; if ({hilo_stall, mul_start} !== 2'b01) begin
      n_err++; $display("FAIL b2b_second_accept got=%b exp=01", {hilo_stall, mul_start}); end
`ifdef HILO_CTRL_ACC_EN
    m_hilo = first + 64'd30;
`else
    m_hilo = 64'd30;
`endif
    exp_q.push_back(m_hilo);
    step(); idle();
    for (int k = 1; k <= MUL_LAT; k++) begin @(negedge clock); step(); end
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({hi, lo} !== exp_v) begin n_err++; $display("FAIL b2b_second got=%h exp=%h", {hi, lo}, exp_v); end
    step();
  endtask

  task automatic test_illegal();
    drive(4'd12, 32'h1111_1111, 32'h2222_2222);
    exp_q.push_back(m_hilo);
    @(negedge clock);
    n_vec++; if ({op_illegal, mul_start, div_start} !== 3'b100) begin
      n_err++; $display("FAIL illegal_pulse got=%b exp=100", {op_illegal, mul_start, div_start}); end
    step(); idle();
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({hi, lo, op_illegal, busy} !== {exp_v, 2'b00}) begin
      n_err++; $display("FAIL illegal_hold got=%h/%b exp=%h/00", {hi, lo}, {op_illegal, busy}, exp_v); end
    step();
    // Launch a multiply, then present an illegal code while busy: stalled, not rejected.
    drive(4'd3, 32'h0001_0000, 32'h0001_0000);
    m_hilo = 64'h0000_0001_0000_0000;
    exp_q.push_back(m_hilo);
    @(negedge clock); step();
    drive(4'd15, 32'd0, 32'd0);
    @(negedge clock);
    n_vec++; if ({op_illegal, hilo_stall} !== 2'b01) begin
      n_err++; $display("FAIL illegal_busy got=%b exp=01", {op_illegal, hilo_stall}); end
    step(); idle();
    for (int k = 2; k <= MUL_LAT; k++) begin @(negedge clock); step(); end
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({hi, lo} !== exp_v) begin n_err++; $display("FAIL multu_hilo got=%h exp=%h", {hi, lo}, exp_v); end
    step();
  endtask

  task automatic test_flush();
    drive(4'd0, 32'hFFFF_FFF9, 32'd2);
    @(negedge clock);
    n_vec++; if ({div_start, div_signed} !== 2'b11) begin
      n_err++; $display("FAIL div_launch got=%b exp=11", {div_start, div_signed}); end
    step(); idle();
    ex_flush = 1'b1; drive(4'd10, 32'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_vec++; if ({busy, hilo_stall, div_start} !== 3'b110) begin
        n_err++; $display("FAIL flush_busy cyc=%0d got=%b exp=110", k, {busy, hilo_stall, div_start}); end
      step();
    end
    idle();
    div_done = 1'b1; div_quotient = 32'hFFFF_FFFD; div_remainder = 32'hFFFF_FFFF;
    m_hilo = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    exp_q.push_back(m_hilo);
    @(negedge clock); step(); idle();
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({hi, lo} !== exp_v) begin n_err++; $display("FAIL flush_commit got=%h exp=%h", {hi, lo}, exp_v); end
    step();
    // MTHI with flush, then MTLO with stall: neither is accepted.
    drive(4'd8, 32'hAAAA_AAAA, 32'd0); ex_flush = 1'b1;
    exp_q.push_back(m_hilo);
    @(negedge clock);
    n_vec++; if ({op_illegal, mul_start, div_start} !== 3'b000) begin
      n_err++; $display("FAIL flush_mthi_pulses got=%b exp=000", {op_illegal, mul_start, div_start}); end
    step(); idle();
    drive(4'd9, 32'd0, 32'hBBBB_BBBB); ex_stall = 1'b1;
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({hi, lo} !== exp_v) begin n_err++; $display("FAIL flush_mthi got=%h exp=%h", {hi, lo}, exp_v); end
    exp_q.push_back(m_hilo);
    step();
    op_code = 4'd13;
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({hi, lo} !== exp_v) begin n_err++; $display("FAIL stall_mtlo got=%h exp=%h", {hi, lo}, exp_v); end
    n_vec++; if (op_illegal !== 1'b0) begin n_err++; $display("FAIL stall_illegal got=%b exp=0", op_illegal); end
    step(); idle();
  endtask

  task automatic test_reset_mid_op();
    drive(4'd0, 32'd9, 32'd3);
    @(negedge clock); step(); idle();
    @(negedge clock); step();
    reset = 1'b1;
    #1;
    m_hilo = 64'd0;
    n_vec++; if ({busy, hi, lo} !== {1'b0, m_hilo}) begin
      n_err++; $display("FAIL reset_mid got=%b/%h exp=0/%h", busy, {hi, lo}, m_hilo); end
    @(negedge clock); step();
    reset = 1'b0;
    div_done = 1'b1; div_quotient = 32'h55; div_remainder = 32'h66;
    exp_q.push_back(m_hilo);
    @(negedge clock); step(); idle();
    @(negedge clock);
    exp_v = exp_q.pop_front();
    n_vec++; if ({busy, hi, lo} !== {1'b0, exp_v}) begin
      n_err++; $display("FAIL reset_stray_done got=%b/%h exp=0/%h", busy, {hi, lo}, exp_v); end
    step();
  endtask

  initial begin
    for (int i = 0; i < MUL_LAT; i++) mpipe[i] = JUNK64;
    mul_product = JUNK64;
    m_hilo = 64'd0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_accumulate();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
